// File: rtl/morse_encoder_tx.sv
// Morse transmitter: accepts {len[2:0],pattern[4:0]} codes over a valid/ready handshake
// and keys marks/spaces on `key` with standard unit timing (dot=1U, dash=3U, gaps 1U/3U/4U).
module morse_encoder_tx #(
  parameter int TIMER_FINAL_VALUE = 4_999_999
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic       key,
  output logic       busy,
  output logic       done
);

  localparam int            TW       = (TIMER_FINAL_VALUE > 0) ? $clog2(TIMER_FINAL_VALUE + 1) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMER_FINAL_VALUE);

  typedef enum logic [2:0] {IDLE, MARK, SPACE, LGAP, WGAP} state_t;

  state_t        state, next_state;
  logic [TW-1:0] tmr;        // cycles within the current unit
  logic [1:0]    ucnt;       // units elapsed within the current interval
  logic [1:0]    last_unit;  // index of the final unit of the current interval
  logic [2:0]    elem;       // bit of pattern being sent; counts down to 0
  logic [4:0]    pattern;
  logic [2:0]    in_len;
  logic          accept, len_ok, is_wgap, unit_end, ivl_end, finish;

  assign in_len     = code_in[7:5];
  assign code_ready = (state == IDLE);
  assign busy       = ~code_ready;
  assign accept     = code_valid & code_ready;
  assign len_ok     = (in_len != 3'd0) && (in_len <= 3'd5);
  assign is_wgap    = (code_in == 8'hE0);
  assign unit_end   = (tmr == TMR_LAST);
  assign ivl_end    = unit_end && (ucnt == last_unit);

  // NOTE: every signal written here gets a default first, otherwise a path that skips it infers a latch.
  always_comb begin
    next_state = state;
    last_unit  = 2'd0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (len_ok)       next_state = MARK;
          else if (is_wgap) next_state = WGAP;
        end
      end
      MARK: begin
        last_unit = pattern[elem] ? 2'd2 : 2'd0;
        if (ivl_end) next_state = (elem == 3'd0) ? LGAP : SPACE;
      end
      SPACE: begin
        if (ivl_end) next_state = MARK;
      end
      LGAP: begin
        last_unit = 2'd2;
        if (ivl_end) begin
          next_state = IDLE;
          finish     = 1'b1;
        end
      end
      WGAP: begin
        last_unit = 2'd3;
        if (ivl_end) begin
          next_state = IDLE;
          finish     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr     <= '0;
      ucnt    <= 2'd0;
      elem    <= 3'd0;
      pattern <= 5'd0;
      key     <= 1'b0;
      done    <= 1'b0;
    end else begin
      // key follows the state being entered, so it is glitch-free and aligned with it
      key  <= (next_state == MARK);
      done <= finish;

      if (next_state != state || state == IDLE) begin
        tmr  <= '0;
        ucnt <= 2'd0;
      end else if (unit_end) begin
        tmr  <= '0;
        ucnt <= ucnt + 2'd1;
      end else begin
        tmr  <= tmr + 1'b1;
      end

      if (state == IDLE && accept && len_ok) begin
        elem    <= in_len - 3'd1;
        pattern <= code_in[4:0];
      end else if (state == MARK && ivl_end && elem != 3'd0) begin
        elem <= elem - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_morse_encoder_tx.sv
// Scoreboarded bench for morse_encoder_tx with U = 4 cycles: expected per-cycle
// {key,done,code_ready,busy} is queued at accept and compared cycle by cycle.
module tb_morse_encoder_tx;

  localparam int TFV = 3;
  localparam int U   = TFV + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] code_in = 8'h00;
  logic       code_valid = 1'b0;
  logic       code_ready, key, busy, done;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] exp_q[$];

  morse_encoder_tx #(.TIMER_FINAL_VALUE(TFV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .key        (key),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Expected waveform from accept to the done cycle, one entry per clock.
  task automatic push_code(input logic [7:0] c);
    int len;
    len = int'(c[7:5]);
    if (c == 8'hE0) begin
      repeat (4*U) exp_q.push_back(4'b0001);
    end else begin
      for (int i = len - 1; i >= 0; i--) begin
        repeat ((c[i] ? 3 : 1) * U) exp_q.push_back(4'b1001);
        if (i > 0) repeat (U) exp_q.push_back(4'b0001);
      end
      repeat (3*U) exp_q.push_back(4'b0001);
    end
    exp_q.push_back(4'b0110);
  endtask

  // Pops n entries (0 = until empty), comparing one per falling edge.
  task automatic drain(input int n);
    int k;
    logic [3:0] e, a;
    k = 0;
    while (exp_q.size() > 0 && (n == 0 || k < n)) begin
      @(negedge clk);
      e = exp_q.pop_front();
      a = {key, done, code_ready, busy};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL waveform step %0d: key/done/ready/busy got %b want %b", k, a, e);
      end
      k++;
    end
  endtask

  task automatic send(input logic [7:0] c);
    int t;
    t = 0;
    @(negedge clk);
    while (code_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (code_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_wait: code_ready got %b want 1 within 200 cycles", code_ready);
    end
    code_in    = c;
    code_valid = 1'b1;
    push_code(c);
    @(posedge clk);
    #1 code_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({key, done, code_ready, busy} !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_state: got %b want 0010", {key, done, code_ready, busy});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_letters();
    logic [7:0] codes[5] = '{8'h20, 8'h41, 8'hBF, 8'h3E, 8'hA5};
    foreach (codes[i]) begin
      send(codes[i]);
      drain(0);
    end
  endtask

  task automatic test_word_gap();
    send(8'hE0);
    drain(0);
  endtask

  task automatic test_discard();
    logic [7:0] codes[4] = '{8'h00, 8'hC5, 8'hE1, 8'hFF};
    foreach (codes[i]) begin
      @(negedge clk);
      code_in    = codes[i];
      code_valid = 1'b1;
      @(posedge clk);
      #1 code_valid = 1'b0;
      repeat (4) begin
        @(negedge clk);
        vectors++;
        if ({key, done, code_ready, busy} !== 4'b0010) begin
          miscompares++;
          $display("FAIL discard %h: got %b want 0010", codes[i], {key, done, code_ready, busy});
        end
      end
    end
  endtask

  // 'T' with valid held; code_in switches to 'E' mid-send and must be taken in the done cycle.
  task automatic test_back_to_back();
    @(negedge clk);
    code_in    = 8'h21;
    code_valid = 1'b1;
    push_code(8'h21);
    push_code(8'h20);
    @(posedge clk);
    #1 code_in = 8'h20;
    drain(6*U + 1);
    @(posedge clk);
    #1 code_valid = 1'b0;
    drain(0);
  endtask

  task automatic test_reset_mid();
    send(8'h41);
    drain(14);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({key, done, code_ready, busy} !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_mid: got %b want 0010", {key, done, code_ready, busy});
    end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({key, done, code_ready, busy} !== 4'b0010) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b want 0010", {key, done, code_ready, busy});
    end
    send(8'h20);
    drain(0);
  endtask

  initial begin
    test_reset();
    test_letters();
    test_word_gap();
    test_discard();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
